// File: rtl/fir2d_filter_param_if.sv
// Video and coefficient bus for the parametrised 2D FIR filter.
// The slave side belongs to the filter; the master side belongs to whoever drives it.
interface fir2d_filter_param_if #(
   parameter int DW = 8,
   parameter int CW = 8
);
   logic [DW-1:0]        y_i;
   logic                 dv_i;
   logic                 hs_i;
   logic                 vs_i;
   logic                 coef_we;
   logic [4:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 bypass;
   logic [DW-1:0]        r_o;
   logic [DW-1:0]        g_o;
   logic [DW-1:0]        b_o;
   logic                 dv_o;
   logic                 hs_o;
   logic                 vs_o;
   logic [10:0]          x_index;
   logic [9:0]           y_index;

   modport slave (
      input  y_i, dv_i, hs_i, vs_i, coef_we, coef_addr, coef_data, bypass,
      output r_o, g_o, b_o, dv_o, hs_o, vs_o, x_index, y_index
   );

   modport master (
      output y_i, dv_i, hs_i, vs_i, coef_we, coef_addr, coef_data, bypass,
      input  r_o, g_o, b_o, dv_o, hs_o, vs_o, x_index, y_index
   );
endinterface

// File: rtl/fir2d_filter_param.sv
// KSIZE x KSIZE programmable FIR on streamed luma, grayscale result on r/g/b.
// Four-stage pipeline: window, multiply, adder tree, round/saturate.
module fir2d_filter_param #(
   parameter int DW    = 8,
   parameter int KSIZE = 5,
   parameter int MAX_W = 1920,
   parameter int CW    = 8,
   parameter int SHIFT = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   fir2d_filter_param_if.slave  bus
);
   localparam int KK   = KSIZE * KSIZE;
   localparam int NLB  = KSIZE - 1;
   localparam int HALF = (KSIZE - 1) / 2;
   localparam int CTR  = HALF * KSIZE + HALF;
   localparam int PW   = DW + 1 + CW;
   localparam int ACCW = DW + CW + 5;
   localparam int LAT  = 4;
   localparam int ADW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   localparam logic signed [CW-1:0]   UNITY = CW'(1 << SHIFT);
   localparam logic signed [ACCW-1:0] RND   = ACCW'(1 << (SHIFT - 1));
   localparam logic signed [ACCW-1:0] PMAX  = ACCW'((1 << DW) - 1);

   // ------------------------------------------------------------------
   // Input counters and sync edge detection
   // ------------------------------------------------------------------
   logic [10:0] x_reg, x_next;
   logic [9:0]  y_reg, y_next;
   logic        hs_d_reg, vs_d_reg;
   logic        hs_rise, vs_rise;
   logic        in_range;

   assign hs_rise  = bus.hs_i & ~hs_d_reg;
   assign vs_rise  = bus.vs_i & ~vs_d_reg;
   assign in_range = int'(x_reg) < MAX_W;

   always_comb begin
      x_next = x_reg;
      if (hs_rise)
         x_next = '0;
      else if (bus.dv_i && (x_reg != '1))
         x_next = x_reg + 11'd1;
      y_next = y_reg;
      if (vs_rise)
         y_next = '0;
      else if (hs_rise && (y_reg != '1))
         y_next = y_reg + 10'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_reg    <= '0;
         y_reg    <= '0;
         hs_d_reg <= 1'b0;
         vs_d_reg <= 1'b0;
      end else begin
         x_reg    <= x_next;
         y_reg    <= y_next;
         hs_d_reg <= bus.hs_i;
         vs_d_reg <= bus.vs_i;
      end
   end

   // ------------------------------------------------------------------
   // Line buffers. The read address runs one step ahead (x_next) so the
   // registered read already holds column x when pixel x arrives.
   // ------------------------------------------------------------------
   logic [ADW-1:0] wr_addr, rd_addr;
   logic           lb_we;
   logic [DW-1:0]  lb_rd [NLB];

   assign wr_addr = ADW'(x_reg);
   assign rd_addr = (int'(x_next) < MAX_W) ? ADW'(x_next) : '0;
   assign lb_we   = bus.dv_i & in_range;

   generate
      for (genvar gi = 0; gi < NLB; gi++) begin : g_lb
         logic [DW-1:0] mem [MAX_W];
         logic [DW-1:0] rd_reg;
         logic [DW-1:0] wr_data;
         if (gi == 0) begin : g_head
            assign wr_data = bus.y_i;
         end else begin : g_cascade
            assign wr_data = lb_rd[gi-1];
         end
         always_ff @(posedge clk) begin
            if (lb_we)
               mem[wr_addr] <= wr_data;
            rd_reg <= mem[rd_addr];
         end
         assign lb_rd[gi] = rd_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stage 1: window. Row 0 is the current line, column 0 the newest pixel.
   // ------------------------------------------------------------------
   logic [DW-1:0] col_px  [KSIZE];
   logic [DW-1:0] win_reg [KSIZE][KSIZE];
   logic          v1_reg;

   assign col_px[0] = bus.y_i;
   generate
      for (genvar gi = 1; gi < KSIZE; gi++) begin : g_col
         assign col_px[gi] = lb_rd[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
               win_reg[r][c] <= '0;
         v1_reg <= 1'b0;
      end else if (bus.dv_i) begin
         for (int r = 0; r < KSIZE; r++) begin
            win_reg[r][0] <= col_px[r];
            for (int c = 1; c < KSIZE; c++)
               win_reg[r][c] <= win_reg[r][c-1];
         end
         v1_reg <= (x_reg >= 11'(KSIZE - 1)) && (y_reg >= 10'(KSIZE - 1)) && in_range;
      end
   end

   // ------------------------------------------------------------------
   // Coefficient banks: shadow written any time, active loaded on vs rise
   // ------------------------------------------------------------------
   logic signed [CW-1:0] shadow_reg [KK];
   logic signed [CW-1:0] active_reg [KK];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < KK; i++) begin
            shadow_reg[i] <= (i == CTR) ? UNITY : '0;
            active_reg[i] <= (i == CTR) ? UNITY : '0;
         end
      end else begin
         for (int i = 0; i < KK; i++) begin
            if (vs_rise)
               active_reg[i] <= shadow_reg[i];
            if (bus.coef_we && (bus.coef_addr == 5'(i)))
               shadow_reg[i] <= bus.coef_data;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sync delay line, shifts every clock regardless of data
   // ------------------------------------------------------------------
   logic [LAT-1:0] dv_pipe_reg, hs_pipe_reg, vs_pipe_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dv_pipe_reg <= '0;
         hs_pipe_reg <= '0;
         vs_pipe_reg <= '0;
      end else begin
         dv_pipe_reg <= {dv_pipe_reg[LAT-2:0], bus.dv_i};
         hs_pipe_reg <= {hs_pipe_reg[LAT-2:0], bus.hs_i};
         vs_pipe_reg <= {vs_pipe_reg[LAT-2:0], bus.vs_i};
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: multiply. Kernel (r,c) is row-major from the top-left,
   // so it pairs with the window tap that is oldest in both directions.
   // ------------------------------------------------------------------
   logic signed [PW-1:0] prod [KK];
   logic [DW-1:0]        c2_reg;
   logic                 v2_reg;

   generate
      for (genvar gi = 0; gi < KK; gi++) begin : g_mul
         localparam int R = gi / KSIZE;
         localparam int C = gi % KSIZE;
         logic signed [PW-1:0] p_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               p_reg <= '0;
            else if (dv_pipe_reg[0])
               p_reg <= PW'($signed({1'b0, win_reg[KSIZE-1-R][KSIZE-1-C]})) * PW'(active_reg[gi]);
         end
         assign prod[gi] = p_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c2_reg <= '0;
         v2_reg <= 1'b0;
      end else if (dv_pipe_reg[0]) begin
         c2_reg <= win_reg[HALF][HALF];
         v2_reg <= v1_reg;
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: adder tree
   // ------------------------------------------------------------------
   logic signed [ACCW-1:0] sum_comb, sum_reg;
   logic [DW-1:0]          c3_reg;
   logic                   v3_reg;

   always_comb begin
      sum_comb = '0;
      for (int i = 0; i < KK; i++)
         sum_comb = sum_comb + ACCW'(prod[i]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_reg <= '0;
         c3_reg  <= '0;
         v3_reg  <= 1'b0;
      end else if (dv_pipe_reg[1]) begin
         sum_reg <= sum_comb;
         c3_reg  <= c2_reg;
         v3_reg  <= v2_reg;
      end
   end

   // ------------------------------------------------------------------
   // Stage 4: round, shift, clamp; bypass and border blanking
   // ------------------------------------------------------------------
   logic signed [ACCW-1:0] rnd, shifted;
   logic [DW-1:0]          sat_pix;
   logic [DW-1:0]          pix_o_reg;

   always_comb begin
      rnd     = sum_reg + RND;
      shifted = rnd >>> SHIFT;
      if (shifted[ACCW-1])
         sat_pix = '0;
      else if (shifted > PMAX)
         sat_pix = '1;
      else
         sat_pix = shifted[DW-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pix_o_reg <= '0;
      else if (dv_pipe_reg[2])
         pix_o_reg <= !v3_reg ? '0 : (bus.bypass ? c3_reg : sat_pix);
   end

   assign bus.r_o     = pix_o_reg;
   assign bus.g_o     = pix_o_reg;
   assign bus.b_o     = pix_o_reg;
   assign bus.dv_o    = dv_pipe_reg[LAT-1];
   assign bus.hs_o    = hs_pipe_reg[LAT-1];
   assign bus.vs_o    = vs_pipe_reg[LAT-1];
   assign bus.x_index = x_reg;
   assign bus.y_index = y_reg;
endmodule

// File: tb/tb_fir2d_filter_param.sv
// Bench for fir2d_filter_param: frames driven cycle by cycle, outputs compared
// four clocks later against an image-array convolution model.
module tb_fir2d_filter_param;
   localparam int DW    = 8;
   localparam int KSIZE = 5;
   localparam int MAX_W = 1920;
   localparam int CW    = 8;
   localparam int SHIFT = 6;
   localparam int KK    = KSIZE * KSIZE;
   localparam int HALF  = (KSIZE - 1) / 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fir2d_filter_param_if #(.DW(DW), .CW(CW)) bus ();

   fir2d_filter_param #(
      .DW(DW), .KSIZE(KSIZE), .MAX_W(MAX_W), .CW(CW), .SHIFT(SHIFT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit dv, hs, vs, valid;
      int filt, centre;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   img [64][64];
   int   shadow_m [KK];
   int   active_m [KK];
   int   mx, my, last_pix;
   bit   hs_prev, vs_prev;

   task automatic chk(string tag, int obs, int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Direct 2D convolution over the stored image, window anchored at (x-4, y-4).
   function automatic int filt_at(int x, int y);
      int s = 0;
      int v;
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            s += active_m[r*KSIZE + c] * img[y-(KSIZE-1)+r][x-(KSIZE-1)+c];
      v = (s + (1 << (SHIFT - 1))) >>> SHIFT;
      if (v < 0) v = 0;
      if (v > (1 << DW) - 1) v = (1 << DW) - 1;
      return v;
   endfunction

   task automatic model_reset();
      ent_t z;
      z = '{default: 0};
      mx = 0; my = 0; last_pix = 0;
      hs_prev = 1'b0; vs_prev = 1'b0;
      for (int i = 0; i < KK; i++) begin
         shadow_m[i] = (i == HALF*KSIZE + HALF) ? (1 << SHIFT) : 0;
         active_m[i] = shadow_m[i];
      end
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(z);
   endtask

   // One clock: record the applied inputs in the model, advance, then check.
   task automatic tick();
      ent_t e;
      bit   hr, vr;
      hr = bus.hs_i && !hs_prev;
      vr = bus.vs_i && !vs_prev;
      e = '{default: 0};
      e.dv = bus.dv_i; e.hs = bus.hs_i; e.vs = bus.vs_i;
      if (bus.dv_i) begin
         if (mx < 64 && my < 64) img[my][mx] = int'(bus.y_i);
         e.valid = (mx >= KSIZE-1) && (my >= KSIZE-1) && (mx < MAX_W) && (mx < 64) && (my < 64);
         if (e.valid) begin
            e.filt   = filt_at(mx, my);
            e.centre = img[my-HALF][mx-HALF];
         end
      end
      q.push_back(e);
      if (vr) my = 0;
      else if (hr && my < 1023) my++;
      if (hr) mx = 0;
      else if (bus.dv_i && mx < 2047) mx++;
      if (vr) active_m = shadow_m;
      if (bus.coef_we && bus.coef_addr < KK) shadow_m[bus.coef_addr] = int'($signed(bus.coef_data));
      hs_prev = bus.hs_i;
      vs_prev = bus.vs_i;
      @(posedge clk);
      #1;
      chk("x_index", int'(bus.x_index), mx);
      chk("y_index", int'(bus.y_index), my);
      if (q.size() == 4) begin
         e = q.pop_front();
         if (e.dv) last_pix = !e.valid ? 0 : (bus.bypass ? e.centre : e.filt);
         chk("dv_o", int'(bus.dv_o), int'(e.dv));
         chk("hs_o", int'(bus.hs_o), int'(e.hs));
         chk("vs_o", int'(bus.vs_o), int'(e.vs));
         chk("r_o", int'(bus.r_o), last_pix);
         chk("g_o", int'(bus.g_o), last_pix);
         chk("b_o", int'(bus.b_o), last_pix);
      end
   endtask

   task automatic write_coef(int addr, int data);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 5'(addr);
      bus.coef_data = CW'(data);
      tick();
      bus.coef_we   = 1'b0;
   endtask

   // wr_line >= 0: coefficient write after that line; -1: write on the vs rise; -2: none.
   task automatic run_line(int l, int w, int mode, int cval, bit first,
                           int wr_line, int wr_addr, int wr_data, bit rbyp);
      bus.coef_addr = 5'(wr_addr);
      bus.coef_data = CW'(wr_data);
      for (int i = 0; i < 4; i++) begin
         bus.dv_i    = 1'b0;
         bus.hs_i    = (i < 2);
         bus.vs_i    = first && (i < 2);
         bus.coef_we = (wr_line == -1) && first && (i == 0);
         tick();
      end
      bus.coef_we = 1'b0;
      for (int x = 0; x < w; x++) begin
         bus.dv_i = 1'b1;
         case (mode)
            0:       bus.y_i = DW'(x + 16*l);
            1:       bus.y_i = DW'(cval);
            default: bus.y_i = DW'($urandom_range(0, 255));
         endcase
         if (rbyp) bus.bypass = 1'($urandom_range(0, 1));
         tick();
      end
      bus.dv_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.coef_we = (wr_line == l) && (i == 0);
         tick();
      end
      bus.coef_we = 1'b0;
   endtask

   task automatic frame(int w, int h, int mode, int cval,
                        int wr_line, int wr_addr, int wr_data, bit rbyp);
      for (int l = 0; l < h; l++)
         run_line(l, w, mode, cval, (l == 0), wr_line, wr_addr, wr_data, rbyp);
      bus.bypass = 1'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      bus.y_i = '0; bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0;
      bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.bypass = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset r_o", int'(bus.r_o), 0);
      chk("reset dv_o", int'(bus.dv_o), 0);
      chk("reset hs_o", int'(bus.hs_o), 0);
      chk("reset x_index", int'(bus.x_index), 0);
      chk("reset y_index", int'(bus.y_index), 0);
      rst = 1'b1;
      model_reset();

      // Identity kernel from reset on a ramp image
      frame(16, 8, 0, 0, -2, 0, 0, 1'b0);

      // Box kernel on a constant image
      for (int i = 0; i < KK; i++) write_coef(i, 1);
      frame(16, 8, 1, 100, -2, 0, 0, 1'b0);

      // Saturation high and low
      for (int i = 0; i < KK; i++) write_coef(i, (i == 12) ? 127 : 0);
      frame(8, 6, 1, 255, -2, 0, 0, 1'b0);
      write_coef(12, -64);
      frame(8, 6, 1, 50, -2, 0, 0, 1'b0);

      // Shadow bank timing: mid-frame write, out-of-range write, vs-coincident write
      write_coef(12, 64);
      frame(8, 6, 1, 200, -2, 0, 0, 1'b0);
      frame(8, 6, 1, 200, 2, 12, 32, 1'b0);
      frame(8, 6, 1, 200, -2, 0, 0, 1'b0);
      frame(8, 6, 1, 200, 1, 25, 5, 1'b0);
      frame(8, 6, 1, 200, -2, 0, 0, 1'b0);
      frame(8, 6, 1, 200, -1, 12, 64, 1'b0);
      frame(8, 6, 1, 200, -2, 0, 0, 1'b0);

      // Random kernel, random pixels, bypass toggling per pixel
      for (int i = 0; i < KK; i++) write_coef(i, int'($urandom_range(0, 60)) - 20);
      frame(12, 7, 2, 0, -2, 0, 0, 1'b1);
      for (int i = 0; i < KK; i++) write_coef(i, int'($urandom_range(-0, 40)) - 10);
      frame(10, 8, 2, 0, -2, 0, 0, 1'b1);

      // Reset in the middle of a line with a non-identity kernel active
      for (int i = 0; i < KK; i++) write_coef(i, int'($urandom_range(1, 10)));
      for (int l = 0; l < 5; l++) run_line(l, 12, 1, 100, (l == 0), -2, 0, 0, 1'b0);
      bus.hs_i = 1'b1; tick(); tick();
      bus.hs_i = 1'b0; tick(); tick();
      for (int x = 0; x < 8; x++) begin
         bus.dv_i = 1'b1; bus.y_i = DW'(100); tick();
      end
      rst = 1'b0;
      bus.dv_i = 1'b0;
      #2;
      chk("async r_o", int'(bus.r_o), 0);
      chk("async g_o", int'(bus.g_o), 0);
      chk("async b_o", int'(bus.b_o), 0);
      chk("async dv_o", int'(bus.dv_o), 0);
      chk("async x_index", int'(bus.x_index), 0);
      chk("async y_index", int'(bus.y_index), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) tick();
      frame(16, 8, 0, 0, -2, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fir2d_filter_param.md
Name: fir2d_filter_param

Overview:
- Parametrised 2D FIR image filter, successor to the fixed 5-pixel buffered luma filter.
- Takes a streamed 8-bit luma video (y_i with dv/hs/vs) and convolves it with a KSIZE×KSIZE run-time-programmable signed kernel, using KSIZE-1 line buffers.
- Normalises the result by round, shift and saturate, then drives the grayscale result on r/g/b with delay-matched sync.
- Sits between the video input decoder and the RGB output stage.

Parameters:
- DW, 8: pixel width (y_i and r/g/b).
- KSIZE, 5: kernel size; odd, 3 or 5 legal.
- MAX_W, 1920: line-buffer depth (max active pixels per line).
- CW, 8: signed coefficient width.
- SHIFT, 6: normalisation right shift (unity gain = 1<<SHIFT).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- y_i  in  DW  input luma pixel.
- dv_i  in  1  input pixel valid, active-high.
- hs_i  in  1  horizontal sync, active-high.
- vs_i  in  1  vertical sync, active-high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  5  coefficient index, row-major r*KSIZE+c.
- coef_data  in  CW  signed coefficient value.
- bypass  in  1  1 = output the unfiltered centre pixel.
- r_o, g_o, b_o  out  DW each  filtered pixel, identical on all three.
- dv_o, hs_o, vs_o  out  1 each  delayed dv/hs/vs.
- x_index  out  11  input column counter.
- y_index  out  10  input line counter.

Behaviour:
- Reset (rst=0, async):
  - All outputs, counters, window and pipeline registers go to 0.
  - Active and shadow coefficient banks load identity: centre = 1<<SHIFT, all others 0.
  - Line-buffer contents are don't-care.
- Counters:
  - x_index increments on each dv_i=1 cycle.
  - x_index clears on the rising edge of hs_i.
  - y_index increments on the rising edge of hs_i.
  - y_index clears on the rising edge of vs_i; vs has priority when hs and vs rise in the same cycle.
  - Both counters saturate at all-ones.
- Line buffers:
  - On dv_i, pixel is written at address x_index into buffer 0; buffer n's old value moves to buffer n+1 (cascade).
  - Pixels with x_index >= MAX_W are not stored; they output 0 but still assert dv_o.
- Window: KSIZE×KSIZE register array shifts one column per dv_i.
- Window valid: x_index >= KSIZE-1 and y_index >= KSIZE-1 for the sampled pixel. Otherwise the output value is 0 (border blanking); dv_o is unaffected.
- Spatial offset: output corresponds to the window centred at (x-(KSIZE-1)/2, y-(KSIZE-1)/2).
- Arithmetic:
  - Pixel is zero-extended to DW+1 signed and multiplied by the signed coefficient.
  - Products are summed in DW+CW+5 bits signed.
  - Add 1<<(SHIFT-1), arithmetic shift right by SHIFT.
  - Clamp to [0, 2^DW-1].
- Pipeline, fixed latency LAT=4 clocks from y_i/dv_i sample to r/g/b/dv_o:
  - Stage 1: window.
  - Stage 2: multiply.
  - Stage 3: adder tree.
  - Stage 4: round/saturate register.
- hs_o and vs_o are hs_i and vs_i delayed exactly LAT. Sync outputs never depend on the data path.
- Coefficient writes:
  - coef_we=1 writes coef_data to shadow[coef_addr].
  - coef_addr >= KSIZE*KSIZE is ignored.
  - Shadow copies to active on the rising edge of vs_i. A write in the same cycle as the vs rising edge lands in shadow only and is applied at the next frame.
- bypass:
  - Selects the centre window pixel, delayed to the same LAT; border blanking still applies.
  - Sampled at stage 4, so it takes effect on the next output.
- No dv_i: window, pipeline data and counters hold. Sync delay line still shifts every clock.
- Reset mid-frame: all pipeline state flushed. No output until a new dv_i arrives, and the window refills from the next line.

Test Plan:
- Identity (reset) kernel, 16×8 frame, y_i = x+16*y:
  - Interior r_o equals input at (x-2, y-2).
  - Border outputs are 0.
  - dv_o/hs_o/vs_o equal inputs delayed exactly 4 clocks.
- Constant image 100, all 25 coefficients = 1: interior output = (2500+32)>>6 = 39 on r_o, g_o and b_o.
- Saturation:
  - Centre coefficient 127, input 255 → output 255.
  - Centre coefficient -64, input 50 → output 0.
- Shadow timing:
  - Write centre coefficient 32 mid-frame on constant 200 → output stays 200 until the next vs_i rising edge, then 100.
  - Write at addr 25 → no change.
- bypass toggled mid-line → output switches to the centre pixel on the next output, with latency still 4.
- rst pulsed low mid-line:
  - All outputs are 0 immediately (async).
  - Coefficients revert to identity.
  - Counters restart at 0.
  - No dv_o until the next dv_i+4.
